// File: rtl/main_memory.sv
// Behavioural main-memory model serving the L2 request channel: one request at a
// time, fixed read latency, saturating read/write statistics counters.
module main_memory #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 1,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req_valid,
  output logic              mem_req_ready,
  input  logic              mem_req_rw,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [DATA_W-1:0] mem_req_data,
  output logic              mem_resp_valid,
  output logic [DATA_W-1:0] mem_resp_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LAT_W = 8;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_TWO  = LAT_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(1);
  localparam bit   SINGLE_CYCLE         = (LATENCY == 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic              accept;
  logic              rw_q;
  logic [DATA_W-1:0] line_q;
  logic              resp_valid_nxt;
  logic [DATA_W-1:0] resp_data_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  // Ready is a pure state decode so it never combinationally follows valid.
  assign mem_req_ready = (state == IDLE);

  // State and latency counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  // Next state plus the response that must be visible in the final busy cycle.
  always_comb begin
    state_nxt      = state;
    lat_cnt_nxt    = lat_cnt;
    accept         = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_data_nxt  = '0;
    case (state)
      IDLE: begin
        if (mem_req_valid) begin
          accept      = 1'b1;
          state_nxt   = BUSY;
          lat_cnt_nxt = LAT_LOAD;
          if (SINGLE_CYCLE && !mem_req_rw) begin
            resp_valid_nxt = 1'b1;
            resp_data_nxt  = mem[mem_req_addr];
          end
        end
      end
      BUSY: begin
        lat_cnt_nxt = lat_cnt - LAT_ONE;
        if (lat_cnt == LAT_ONE) begin
          state_nxt = IDLE;
        end
        if (lat_cnt == LAT_TWO && !rw_q) begin
          resp_valid_nxt = 1'b1;
          resp_data_nxt  = line_q;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture and array write at the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q   <= 1'b0;
      line_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (accept) begin
      rw_q <= mem_req_rw;
      if (mem_req_rw) begin
        mem[mem_req_addr] <= mem_req_data;
      end else begin
        line_q <= mem[mem_req_addr];
      end
    end
  end

  // Registered response: data is forced to zero outside the pulse cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
    end else begin
      mem_resp_valid <= resp_valid_nxt;
      mem_resp_data  <= resp_data_nxt;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (accept) begin
      if (mem_req_rw) begin
        if (wr_count != CNT_MAX) wr_count <= wr_count + CNT_INC;
      end else begin
        if (rd_count != CNT_MAX) rd_count <= rd_count + CNT_INC;
      end
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Randomized self-checking bench for main_memory against an array/counter
// reference model; one instance at LATENCY=4 and one at LATENCY=1.
module tb_main_memory;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 1;
  localparam int unsigned CNT_W  = 8;
  localparam int          LAT    = 4;
  localparam int          SAT    = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              v4, rw4, rdy4, rv4;
  logic [ADDR_W-1:0] a4;
  logic [DATA_W-1:0] d4, rd4;
  logic [CNT_W-1:0]  rc4, wc4;

  logic              v1, rw1, rdy1, rv1;
  logic [ADDR_W-1:0] a1;
  logic [DATA_W-1:0] d1, rd1;
  logic [CNT_W-1:0]  rc1, wc1;

  main_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT), .CNT_W(CNT_W)) u_dut4 (
    .clk(clk), .reset(reset),
    .mem_req_valid(v4), .mem_req_ready(rdy4), .mem_req_rw(rw4),
    .mem_req_addr(a4), .mem_req_data(d4),
    .mem_resp_valid(rv4), .mem_resp_data(rd4),
    .rd_count(rc4), .wr_count(wc4)
  );

  main_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(1), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .reset(reset),
    .mem_req_valid(v1), .mem_req_ready(rdy1), .mem_req_rw(rw1),
    .mem_req_addr(a1), .mem_req_data(d1),
    .mem_resp_valid(rv1), .mem_resp_data(rd1),
    .rd_count(rc1), .wr_count(wc1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: line contents and saturating counts.
  logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
  int ref_rd, ref_wr;

  function automatic void model_clear();
    for (int i = 0; i < (1 << ADDR_W); i++) ref_mem[i] = '0;
    ref_rd = 0;
    ref_wr = 0;
  endfunction

  // One transaction on the LATENCY=4 instance, checking every busy cycle.
  task automatic issue4(input logic rw, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input string tag);
    logic [DATA_W-1:0] exp_line;
    logic exp_v;
    logic [DATA_W-1:0] exp_d;
    @(negedge clk);
    v4 = 1'b1; rw4 = rw; a4 = addr; d4 = data;
    total++;
    if (rdy4 !== 1'b1) begin
      bad++; $display("FAIL %s ready_before_accept: got %b want 1", tag, rdy4);
    end
    @(posedge clk); #1;
    v4 = 1'b0;
    if (rw) begin
      ref_mem[addr] = data;
      if (ref_wr < SAT) ref_wr++;
    end else begin
      if (ref_rd < SAT) ref_rd++;
    end
    exp_line = ref_mem[addr];
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      exp_v = (!rw && k == LAT);
      exp_d = exp_v ? exp_line : '0;
      total++;
      if (rdy4 !== 1'b0 || rv4 !== exp_v || rd4 !== exp_d) begin
        bad++;
        $display("FAIL %s cycle%0d: ready=%b valid=%b data=%h want ready=0 valid=%b data=%h",
                 tag, k, rdy4, rv4, rd4, exp_v, exp_d);
      end
      if (k == 1) begin
        total++;
        if (rc4 !== CNT_W'(ref_rd) || wc4 !== CNT_W'(ref_wr)) begin
          bad++;
          $display("FAIL %s counts: rd=%0d wr=%0d want rd=%0d wr=%0d", tag, rc4, wc4, ref_rd, ref_wr);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    v4 = 1'b0; rw4 = 1'b0; a4 = '0; d4 = '0;
    v1 = 1'b0; rw1 = 1'b0; a1 = '0; d1 = '0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (rdy4 !== 1'b1 || rv4 !== 1'b0 || rd4 !== '0 || rc4 !== '0 || wc4 !== '0) begin
      bad++;
      $display("FAIL reset_state: ready=%b valid=%b data=%h rd=%0d wr=%0d want 1 0 0 0 0",
               rdy4, rv4, rd4, rc4, wc4);
    end
    total++;
    if (rdy1 !== 1'b1 || rv1 !== 1'b0 || rc1 !== '0 || wc1 !== '0) begin
      bad++;
      $display("FAIL reset_state_lat1: ready=%b valid=%b rd=%0d wr=%0d want 1 0 0 0", rdy1, rv1, rc1, wc1);
    end
  endtask

  task automatic test_write_read();
    issue4(1'b1, 6'h2A, 1'b1, "wr_2a");
    issue4(1'b0, 6'h2A, 1'b0, "rd_2a");
    @(negedge clk);
    total++;
    if (wc4 !== 8'd1 || rc4 !== 8'd1 || rdy4 !== 1'b1) begin
      bad++;
      $display("FAIL write_read_counts: wr=%0d rd=%0d ready=%b want 1 1 1", wc4, rc4, rdy4);
    end
  endtask

  task automatic test_unwritten();
    issue4(1'b0, 6'h05, 1'b1, "rd_unwritten_05");
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] ad [3];
    int acc [$];
    int rsp_cyc [$];
    logic [DATA_W-1:0] rsp [$];
    int idx;
    issue4(1'b1, 6'h3F, 1'b1, "wr_3f");
    ad[0] = 6'h3F; ad[1] = 6'h00; ad[2] = 6'h3F;
    @(negedge clk);
    idx = 0; v4 = 1'b1; rw4 = 1'b0; a4 = ad[0]; d4 = '0;
    for (int c = 0; c < 60 && rsp.size() < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (rv4 === 1'b1) begin rsp.push_back(rd4); rsp_cyc.push_back(cyc); end
      if (rdy4 === 1'b1 && v4) begin
        @(posedge clk); #1;
        acc.push_back(cyc);
        idx++;
        if (idx < 3) a4 = ad[idx]; else v4 = 1'b0;
      end
    end
    v4 = 1'b0;
    total++;
    if (acc.size() != 3 || rsp.size() != 3) begin
      bad++;
      $display("FAIL b2b_counts: accepts=%0d responses=%0d want 3 3", acc.size(), rsp.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rsp[i] !== ref_mem[ad[i]] || rsp_cyc[i] != acc[i] + LAT - 1) begin
          bad++;
          $display("FAIL b2b_resp%0d: data=%h at offset %0d want data=%h offset %0d",
                   i, rsp[i], rsp_cyc[i] - acc[i] + 1, ref_mem[ad[i]], LAT);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (acc[i] - acc[i-1] != LAT + 1) begin
          bad++;
          $display("FAIL b2b_spacing%0d: got %0d want %0d", i, acc[i] - acc[i-1], LAT + 1);
        end
      end
    end
    for (int i = 0; i < 3; i++) if (ref_rd < SAT) ref_rd++;
    @(negedge clk);
    total++;
    if (rc4 !== CNT_W'(ref_rd) || rdy4 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rd_count: rd=%0d ready=%b want %0d 1", rc4, rdy4, ref_rd);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      issue4(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 63)),
             DATA_W'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_latency_one();
    @(negedge clk);
    v1 = 1'b1; rw1 = 1'b1; a1 = 6'h10; d1 = 1'b1;
    @(posedge clk); #1; v1 = 1'b0;
    @(negedge clk);
    total++;
    if (rdy1 !== 1'b0 || rv1 !== 1'b0 || rd1 !== '0) begin
      bad++; $display("FAIL lat1_write_busy: ready=%b valid=%b data=%h want 0 0 0", rdy1, rv1, rd1);
    end
    @(negedge clk);
    total++;
    if (rdy1 !== 1'b1) begin
      bad++; $display("FAIL lat1_write_done: ready=%b want 1", rdy1);
    end
    v1 = 1'b1; rw1 = 1'b0; a1 = 6'h10;
    @(posedge clk); #1; v1 = 1'b0;
    @(negedge clk);
    total++;
    if (rdy1 !== 1'b0 || rv1 !== 1'b1 || rd1 !== 1'b1) begin
      bad++; $display("FAIL lat1_read_resp: ready=%b valid=%b data=%h want 0 1 1", rdy1, rv1, rd1);
    end
    @(negedge clk);
    total++;
    if (rdy1 !== 1'b1 || rv1 !== 1'b0 || rd1 !== '0 || rc1 !== 8'd1 || wc1 !== 8'd1) begin
      bad++;
      $display("FAIL lat1_after: ready=%b valid=%b data=%h rd=%0d wr=%0d want 1 0 0 1 1",
               rdy1, rv1, rd1, rc1, wc1);
    end
  endtask

  task automatic test_reset_mid_read();
    logic saw;
    issue4(1'b1, 6'h2A, 1'b1, "wr_before_reset");
    @(negedge clk);
    v4 = 1'b1; rw4 = 1'b0; a4 = 6'h2A;
    @(posedge clk); #1; v4 = 1'b0;
    saw = 1'b0;
    repeat (2) begin @(negedge clk); if (rv4 !== 1'b0) saw = 1'b1; end
    reset = 1'b1;
    model_clear();
    repeat (3) begin @(negedge clk); if (rv4 !== 1'b0) saw = 1'b1; end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (rdy4 !== 1'b1) begin
      bad++; $display("FAIL reset_mid_ready: ready=%b want 1", rdy4);
    end
    repeat (5) begin @(negedge clk); if (rv4 !== 1'b0) saw = 1'b1; end
    total++;
    if (saw !== 1'b0) begin
      bad++; $display("FAIL reset_mid_no_resp: saw a response pulse, want none");
    end
    issue4(1'b0, 6'h2A, 1'b0, "reread_after_reset");
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      issue4(1'b1, ADDR_W'($urandom_range(0, 63)), DATA_W'($urandom_range(0, 1)), "sat_write");
    end
    @(negedge clk);
    total++;
    if (wc4 !== 8'd255) begin
      bad++; $display("FAIL wr_count_saturate: got %0d want 255", wc4);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_unwritten();
    test_back_to_back();
    test_random();
    test_latency_one();
    test_reset_mid_read();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_memory.md
Name: main_memory

Overview:
- Behavioural main-memory model that sits directly downstream of the L2 and serves its memory request channel.
- Requests use a valid/ready handshake with line address, read/write and data. Reads return one cacheline after a fixed, parameterised latency.
- Serves one request at a time. Keeps saturating read and write counters for verification and performance checks.

Parameters:
- ADDR_W, 6, line-address width (ADDR_BITS - OFFSET_BITS); the array holds 2^ADDR_W lines.
- DATA_W, 1, cacheline width (CACHELINE_BITS).
- LATENCY, 4, cycles from request acceptance to completion; legal range 1..255.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req_valid  in  1  request present.
- mem_req_ready  out  1  block can accept a request this cycle.
- mem_req_rw  in  1  0 = read, 1 = write.
- mem_req_addr  in  ADDR_W  line address.
- mem_req_data  in  DATA_W  write data; ignored for reads.
- mem_resp_valid  out  1  read data valid; one-cycle pulse.
- mem_resp_data  out  DATA_W  read data.
- rd_count  out  CNT_W  accepted reads, saturating.
- wr_count  out  CNT_W  accepted writes, saturating.

Behaviour:
- Reset, while asserted and asynchronously:
  - state = IDLE, every array line = 0, latency counter = 0.
  - mem_req_ready = 1, mem_resp_valid = 0, mem_resp_data = 0.
  - rd_count = 0, wr_count = 0.
- States: IDLE and BUSY.
  - mem_req_ready = 1 exactly when state is IDLE. It is driven from state only and never depends on mem_req_valid.
- Accept: on a rising edge with state IDLE and mem_req_valid = 1.
  - Latch rw and addr, load the counter with LATENCY, go to BUSY.
  - Read accept: capture array[addr] into the response register at the accept edge.
  - Write accept: array[addr] <= mem_req_data at the accept edge. A read accepted later sees the new value.
  - Increment rd_count or wr_count; hold each counter at 2^CNT_W-1 once it saturates.
- BUSY:
  - Counter decrements each edge.
  - When counter == 1, the next edge returns the block to IDLE.
  - Inputs are ignored while BUSY, including mem_req_valid.
- Timing, with the accept edge ending cycle 0:
  - mem_req_ready = 0 in cycles 1..LATENCY and is 1 again in cycle LATENCY+1.
  - Read: mem_resp_valid = 1 only in cycle LATENCY. mem_resp_data equals the captured line in that cycle and is 0 in all other cycles.
  - Write: no response pulse; completion is indicated only by mem_req_ready returning to 1.
  - LATENCY = 1: ready is low for one cycle, and for a read the response appears in that same cycle.
- Back-to-back: a request held valid during the response cycle is not accepted until cycle LATENCY+1. Throughput is 1 request per LATENCY+1 cycles.
- Requester rule: the requester must hold valid, rw, addr and data stable until accepted. The block does not check this.
- Address wrap: addr is used modulo 2^ADDR_W; no out-of-range behaviour exists.
- Reset mid-operation: an in-flight read produces no response, an in-flight write that was already committed is cleared with the array, and ready is 1 in the first cycle after reset deasserts.
- Outputs are glitch-free register outputs, except mem_req_ready, which is decoded from the state register only.

Test Plan:
- Reset, then idle 5 cycles -> ready = 1, resp_valid = 0, resp_data = 0, rd_count = wr_count = 0.
- LATENCY = 4: write addr 0x2A data 1, then read 0x2A -> no pulse for the write; ready low 4 cycles after each accept; resp_valid only in cycle 4 after the read accept with data 1; wr_count = 1, rd_count = 1.
- Read never-written addr 0x05 -> resp_data = 0.
- Valid held high with 3 queued reads of 0x3F, 0x00 and 0x3F after writing 0x3F = 1 -> accepts spaced exactly 5 cycles apart; responses 1, 0, 1.
- LATENCY = 1, read 0x10 after writing 1 -> ready low one cycle and resp_valid = 1 with data 1 in that same cycle.
- Assert reset 2 cycles into a read -> no resp_valid pulse; after release ready = 1 and a re-read returns 0.
- Issue 300 writes with CNT_W = 8 -> wr_count saturates at 255.
